// File: rtl/guitar_hit_scorer_pkg.sv
// Shared game definitions: FSM states, default tuning and score/multiplier limits.
package guitar_hit_scorer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } game_state_t;

   localparam int unsigned LANES           = 4;
   localparam int unsigned LIVES_INIT_DEF  = 3;
   localparam int unsigned STREAK_STEP_DEF = 8;
   localparam int unsigned MULT_MAX        = 4;
   localparam int unsigned SCORE_MAX       = 65535;
   localparam int unsigned STREAK_MAX      = 255;

endpackage

// File: rtl/guitar_hit_scorer_lane_judge.sv
// Per-lane judge: edge-detects the fret button and tracks whether the current
// window's note on this lane has already been hit.
module lane_judge (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_flag,
   input  logic active,
   input  logic step_tick,
   input  logic note,
   input  logic btn,
   output logic hit,
   output logic wrong,
   output logic unhit_note
);

   logic btn_q;
   logic hit_flag;
   logic press;

   // Classify this cycle's press; a hit in the closing window counts as covering the note.
   always_comb begin
      press      = btn & ~btn_q;
      hit        = active & press & note & ~hit_flag;
      wrong      = active & press & (~note | hit_flag);
      unhit_note = note & ~hit_flag & ~hit;
   end

   // Button history and per-window hit flag; step_tick opens a fresh window.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         btn_q    <= 1'b0;
         hit_flag <= 1'b0;
      end else begin
         btn_q <= btn;
         if (clear_flag || step_tick) begin
            hit_flag <= 1'b0;
         end else if (hit) begin
            hit_flag <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/guitar_hit_scorer.sv
// Rhythm-game scorer: judges four lanes, keeps score/streak/lives and runs the game FSM.
module guitar_hit_scorer
   import guitar_hit_scorer_pkg::*;
#(
   parameter int unsigned LIVES_INIT  = LIVES_INIT_DEF,
   parameter int unsigned STREAK_STEP = STREAK_STEP_DEF
) (
   input  logic        CLOCK_50,
   input  logic        RESET_N,
   input  logic        start,
   input  logic        step_tick,
   input  logic [3:0]  lane_note,
   input  logic [3:0]  btn,
   output logic [15:0] score,
   output logic [7:0]  streak,
   output logic [2:0]  multiplier,
   output logic [2:0]  lives,
   output logic        hit_pulse,
   output logic        miss_pulse,
   output logic        playing,
   output logic        game_over
);

   game_state_t state;
   game_state_t state_next;

   logic        in_play;
   logic        start_game;
   logic [3:0]  lane_hit;
   logic [3:0]  lane_wrong;
   logic [3:0]  lane_unhit;
   logic [2:0]  hit_cnt;
   logic        wrong_any;
   logic        miss_evt;
   logic [16:0] score_sum;
   logic [15:0] score_next;
   logic [8:0]  streak_sum;
   logic [7:0]  streak_next;
   logic [2:0]  lives_next;
   int unsigned mult_level;

   assign in_play    = (state == PLAY);
   assign start_game = start & (state != PLAY);
   assign playing    = (state == PLAY);
   assign game_over  = (state == OVER);

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      lane_judge u_judge (
         .clk        (CLOCK_50),
         .rst_n      (RESET_N),
         .clear_flag (start_game),
         .active     (in_play),
         .step_tick  (step_tick),
         .note       (lane_note[g]),
         .btn        (btn[g]),
         .hit        (lane_hit[g]),
         .wrong      (lane_wrong[g]),
         .unhit_note (lane_unhit[g])
      );
   end

   // Multiplier follows the registered streak, capped at MULT_MAX.
   always_comb begin
      mult_level = 32'(streak) / STREAK_STEP;
      if (mult_level > MULT_MAX - 1) begin
         mult_level = MULT_MAX - 1;
      end
      multiplier = 3'(mult_level + 1);
   end

   // Per-cycle scoring arithmetic with saturation and one life lost per missed window.
   always_comb begin
      hit_cnt = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         hit_cnt = hit_cnt + 3'(lane_hit[i]);
      end
      wrong_any = |lane_wrong;
      miss_evt  = in_play & step_tick & (|lane_unhit);

      score_sum  = 17'(score) + 17'(multiplier) * 17'(hit_cnt);
      score_next = (score_sum > 17'(SCORE_MAX)) ? 16'(SCORE_MAX) : score_sum[15:0];

      streak_sum = 9'(streak) + 9'(hit_cnt);
      if (wrong_any || miss_evt) begin
         streak_next = '0;
      end else if (streak_sum > 9'(STREAK_MAX)) begin
         streak_next = 8'(STREAK_MAX);
      end else begin
         streak_next = streak_sum[7:0];
      end

      lives_next = miss_evt ? (lives - 3'd1) : lives;
   end

   // Game FSM next-state: only start leaves IDLE/OVER, only running out of lives leaves PLAY.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = PLAY;
         PLAY: if (miss_evt && (lives_next == '0)) state_next = OVER;
         OVER: if (start) state_next = PLAY;
         default: state_next = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Score, streak, lives and event pulses; counters freeze outside PLAY.
   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         score      <= '0;
         streak     <= '0;
         lives      <= 3'(LIVES_INIT);
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
      end else if (start_game) begin
         score      <= '0;
         streak     <= '0;
         lives      <= 3'(LIVES_INIT);
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
      end else if (in_play) begin
         score      <= score_next;
         streak     <= streak_next;
         lives      <= lives_next;
         hit_pulse  <= |lane_hit;
         miss_pulse <= miss_evt;
      end else begin
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
      end
   end

endmodule

// File: doc/guitar_hit_scorer.md
GUITAR_HIT_SCORER -- requirements
Module: guitar_hit_scorer

Interface
REQ-001 SHALL have parameter LIVES_INIT, default 3, giving the miss budget per game (1..7).
REQ-002 SHALL have parameter STREAK_STEP, default 8, giving the consecutive hits needed per multiplier increment.
REQ-003 SHALL have ports: CLOCK_50 input 1 (single clock, all logic rising-edge); RESET_N input 1 (synchronous, active-low).
REQ-004 SHALL have ports: start input 1 (pulse, begins a game); step_tick input 1 (one-cycle pulse marking each shifter advance).
REQ-005 SHALL have ports: lane_note input 4 (bottom bit of each lane shifter, a note is live at the hit line); btn input 4 (synchronised, active-high fret buttons).
REQ-006 SHALL have ports: score output 16; streak output 8; multiplier output 3 (1..4); lives output 3.
REQ-007 SHALL have ports: hit_pulse output 1; miss_pulse output 1; playing output 1; game_over output 1.

Function
REQ-008 SHALL implement FSM states IDLE, PLAY, OVER; IDLE->PLAY on start; PLAY->OVER when lives reaches 0; OVER->PLAY on start; no other transitions.
REQ-009 SHALL, on entry to PLAY, set score=0, streak=0, lives=LIVES_INIT, and clear all per-lane hit flags in the same clock edge.
REQ-010 SHALL register btn every cycle and derive press[i] = btn[i] & ~btn_q[i]; held buttons SHALL generate no further presses.
REQ-011 SHALL treat the interval between consecutive step_tick pulses as one window; each lane holds a hit flag cleared on every step_tick.
REQ-012 SHALL count a hit on lane i when press[i]=1, lane_note[i]=1, hit flag i=0, and state=PLAY; it then sets hit flag i.
REQ-013 SHALL count a wrong press on lane i when press[i]=1 in PLAY and either lane_note[i]=0 or hit flag i=1.
REQ-014 SHALL add multiplier (value before the update) to score for each hit lane in a cycle, saturating at 65535.
REQ-015 SHALL increment streak by the number of hit lanes in a cycle, saturating at 255.
REQ-016 SHALL set streak to 0 on any wrong press or miss, overriding hits in the same cycle; the hits still score.
REQ-017 SHALL drive multiplier = 1 + min(streak / STREAK_STEP, 3) combinationally from the registered streak.
REQ-018 SHALL, on step_tick in PLAY, declare a miss if any lane has lane_note=1 with its hit flag clear (including a hit landing in the same cycle).
REQ-019 SHALL decrement lives by exactly 1 per missed window regardless of how many lanes missed.
REQ-020 SHALL evaluate a press coincident with step_tick against the closing window, before flags clear.
REQ-021 SHALL pulse hit_pulse / miss_pulse for one cycle, on the clock edge after the qualifying event; all counters update on that same edge.
REQ-022 SHALL ignore step_tick, btn, and lane_note in IDLE and OVER, while holding score and streak.
REQ-023 SHALL drive playing=1 only in PLAY and game_over=1 only in OVER.

Reset
REQ-024 SHALL, on RESET_N=0 at a clock edge, enter IDLE with score=0, streak=0, lives=LIVES_INIT, btn_q=0, flags=0, hit_pulse=0, miss_pulse=0, playing=0, game_over=0; multiplier then reads 1.
REQ-025 SHALL take reset mid-game with priority over start and all events in the same cycle.

Structure
REQ-026 SHALL place the state encoding, LIVES_INIT/STREAK_STEP defaults, and the MULT_MAX=4 and SCORE_MAX=65535 constants in the shared game package.
REQ-027 SHALL instantiate one sub-module per lane, lane_judge, that holds btn_q and the hit flag and outputs a hit, wrong, or unhit_note indication; scoring, FSM, and lives stay in the top.

Verification
REQ-028 Test 1: reset, then start, then press lane 2 while lane_note=0100 -> score=1, streak=1, hit_pulse for one cycle.
REQ-029 Test 2: 8 consecutive single-lane hits -> multiplier goes 1->2 after the 8th hit; the 9th hit adds 2 (score=10).
REQ-030 Test 3: lane_note=1010 with only lane 3 pressed, then step_tick -> one miss_pulse, lives 3->2, streak=0.
REQ-031 Test 4: lane 0 pressed twice in one window with a note -> first press is a hit and the second is wrong; streak=0, score=1.
REQ-032 Test 5: three missed windows -> lives=0, game_over=1; later step_tick and presses leave score unchanged; start -> PLAY with lives=3 and score=0.
REQ-033 Test 6: RESET_N=0 mid-game with score=37 -> next cycle in IDLE, score=0, multiplier=1, lives=3.
